// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port.
// Also tracks pending writes in a 32-entry scoreboard for RAW stalls.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      rsv_valid,
  input  logic [ADDR_W-1:0]         rsv_reg,
  input  logic [ADDR_W-1:0]         chk_reg_a,
  input  logic [ADDR_W-1:0]         chk_reg_b,
  output logic                      busy_a,
  output logic                      busy_b,
  output logic [31:0]               busy_vec,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   last_q, last_d;
  logic [PTR_W-1:0]   gidx;
  logic               found;
  logic               fire;
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]  sel_data;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  wreg_q, wreg_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [31:0]        busy_q, busy_d;

  // Pick the first valid requester after the last winner.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        gidx  = PTR_W'((int'(last_q) + k) % NUM_REQ);
        grant[(int'(last_q) + k) % NUM_REQ] = 1'b1;
      end
    end
    if (!ctrl_reset) begin
      grant = '0;
    end
  end

  assign req_ready = grant;
  assign fire      = found & ctrl_reset;
  assign sel_reg   = req_reg[int'(gidx)*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[int'(gidx)*DATA_W +: DATA_W];

  // Next-state for pointer and write-port registers.
  always_comb begin
    last_d  = last_q;
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (fire) begin
      last_d  = gidx;
      we_d    = (sel_reg != '0);
      wreg_d  = sel_reg;
      wdata_d = sel_data;
    end
  end

  // Scoreboard: commit clears first, then a reservation may re-set.
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[wreg_q] = 1'b0;
    end
    if (rsv_valid && rsv_reg != '0) begin
      busy_d[rsv_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      last_q  <= PTR_W'(NUM_REQ - 1);
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      last_q  <= last_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign ctrl_writeEnable = we_q;
  assign ctrl_writeReg    = wreg_q;
  assign data_writeReg    = wdata_q;
  assign busy_vec         = busy_q;
  assign busy_a           = busy_q[chk_reg_a];
  assign busy_b           = busy_q[chk_reg_b];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter.
// Each task drives a scenario and checks inline.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [19:0] req_reg = '0;
  logic [127:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_reg = '0;
  logic [4:0]  chk_reg_a = '0;
  logic [4:0]  chk_reg_b = '0;
  logic        busy_a, busy_b;
  logic [31:0] busy_vec;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.NUM_REQ(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .req_valid(req_valid),
    .req_reg(req_reg),
    .req_data(req_data),
    .req_ready(req_ready),
    .rsv_valid(rsv_valid),
    .rsv_reg(rsv_reg),
    .chk_reg_a(chk_reg_a),
    .chk_reg_b(chk_reg_b),
    .busy_a(busy_a),
    .busy_b(busy_b),
    .busy_vec(busy_vec),
    .ctrl_writeEnable(we),
    .ctrl_writeReg(wreg),
    .data_writeReg(wdata)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b0;
    req_valid = 4'b1111;
    req_reg = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_ready: got %b expected 0000", req_ready);
    end
    tick();
    tick();
    n_cmp++;
    if (we !== 1'b0) begin
      n_err++;
      $display("FAIL rst_we: got %b expected 0", we);
    end
    n_cmp++;
    if (busy_vec !== 32'h0) begin
      n_err++;
      $display("FAIL rst_busy: got %h expected 0", busy_vec);
    end
    n_cmp++;
    if (wreg !== 5'd0 || wdata !== 32'h0) begin
      n_err++;
      $display("FAIL rst_wr: got %0d/%h expected 0/0", wreg, wdata);
    end
    ctrl_reset = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_first: got %b expected 0001", req_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    logic [4:0] exp_r [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};
    req_valid = 4'b1111;
    req_reg = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data = {32'h104, 32'h103, 32'h102, 32'h101};
    #1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (req_ready !== exp_g[c]) begin
        n_err++;
        $display("FAIL rr_grant%0d: got %b expected %b",
                 c, req_ready, exp_g[c]);
      end
      tick();
      n_cmp++;
      if (we !== 1'b1 || wreg !== exp_r[c]) begin
        n_err++;
        $display("FAIL rr_write%0d: got we=%b reg=%0d expected 1/%0d",
                 c, we, wreg, exp_r[c]);
      end
      n_cmp++;
      if (wdata !== 32'h100 + 32'(exp_r[c])) begin
        n_err++;
        $display("FAIL rr_data%0d: got %h expected %h",
                 c, wdata, 32'h100 + 32'(exp_r[c]));
      end
    end
    req_valid = 4'b0000;
    tick();
    n_cmp++;
    if (we !== 1'b0 || wreg !== 5'd1 || wdata !== 32'h101) begin
      n_err++;
      $display("FAIL rr_idle: got %b/%0d/%h expected 0/1/101",
               we, wreg, wdata);
    end
  endtask

  task automatic test_r0_write();
    req_valid = 4'b0100;
    req_reg = '0;
    req_data = '0;
    req_data[64 +: 32] = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL r0_grant: got %b expected 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    n_cmp++;
    if (we !== 1'b0 || wreg !== 5'd0 || wdata !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL r0_write: got %b/%0d/%h expected 0/0/deadbeef",
               we, wreg, wdata);
    end
    rsv_valid = 1'b1;
    rsv_reg = 5'd0;
    tick();
    rsv_valid = 1'b0;
    n_cmp++;
    if (busy_vec !== 32'h0) begin
      n_err++;
      $display("FAIL r0_rsv: got %h expected 0", busy_vec);
    end
  endtask

  task automatic test_raw_busy();
    chk_reg_a = 5'd7;
    rsv_valid = 1'b1;
    rsv_reg = 5'd7;
    tick();
    rsv_valid = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL raw_n0: got %b expected 1", busy_a);
    end
    tick();
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_err++;
      $display("FAIL raw_n1: got %b expected 1", busy_a);
    end
    tick();
    req_valid = 4'b0010;
    req_reg = '0;
    req_reg[5 +: 5] = 5'd7;
    req_data = '0;
    req_data[32 +: 32] = 32'h00000055;
    #1;
    n_cmp++;
    if (busy_a !== 1'b1 || req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL raw_n2: got busy=%b ready=%b expected 1/0010",
               busy_a, req_ready);
    end
    tick();
    req_valid = 4'b0000;
    n_cmp++;
    if (busy_a !== 1'b1 || we !== 1'b1 || wreg !== 5'd7 ||
        wdata !== 32'h55) begin
      n_err++;
      $display("FAIL raw_n3: got %b/%b/%0d/%h expected 1/1/7/55",
               busy_a, we, wreg, wdata);
    end
    tick();
    n_cmp++;
    if (busy_a !== 1'b0 || we !== 1'b0) begin
      n_err++;
      $display("FAIL raw_n4: got busy=%b we=%b expected 0/0", busy_a, we);
    end
  endtask

  task automatic test_same_edge();
    chk_reg_b = 5'd9;
    rsv_valid = 1'b1;
    rsv_reg = 5'd9;
    tick();
    rsv_valid = 1'b0;
    req_valid = 4'b1000;
    req_reg = '0;
    req_reg[15 +: 5] = 5'd9;
    req_data = '0;
    req_data[96 +: 32] = 32'h99;
    #1;
    n_cmp++;
    if (req_ready !== 4'b1000) begin
      n_err++;
      $display("FAIL se_grant: got %b expected 1000", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    rsv_valid = 1'b1;
    rsv_reg = 5'd9;
    n_cmp++;
    if (we !== 1'b1 || wreg !== 5'd9) begin
      n_err++;
      $display("FAIL se_commit: got %b/%0d expected 1/9", we, wreg);
    end
    tick();
    rsv_valid = 1'b0;
    n_cmp++;
    if (busy_vec[9] !== 1'b1 || busy_b !== 1'b1) begin
      n_err++;
      $display("FAIL se_busy: got %b/%b expected 1/1",
               busy_vec[9], busy_b);
    end
    tick();
    n_cmp++;
    if (busy_vec !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL se_hold: got %h expected 00000200", busy_vec);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100;
    req_reg = '0;
    req_reg[10 +: 5] = 5'd5;
    req_data = '0;
    req_data[64 +: 32] = 32'h1234;
    rsv_valid = 1'b1;
    rsv_reg = 5'd12;
    tick();
    rsv_valid = 1'b0;
    req_valid = 4'b0000;
    n_cmp++;
    if (we !== 1'b1 || wreg !== 5'd5 || busy_vec[12] !== 1'b1) begin
      n_err++;
      $display("FAIL rm_accept: got %b/%0d/%b expected 1/5/1",
               we, wreg, busy_vec[12]);
    end
    ctrl_reset = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL rm_ready: got %b expected 0000", req_ready);
    end
    tick();
    n_cmp++;
    if (we !== 1'b0 || busy_vec !== 32'h0) begin
      n_err++;
      $display("FAIL rm_state: got %b/%h expected 0/0", we, busy_vec);
    end
    ctrl_reset = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL rm_prio: got %b expected 0001", req_ready);
    end
    req_valid = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_r0_write();
    test_raw_busy();
    test_same_edge();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ writeback requesters (ALU, mult/div, load path, etc.) using round-robin arbitration with a valid/ready handshake.
- Drives the register file write controls from registered outputs.
- Keeps a 32-entry pending-write scoreboard so the issue stage can stall on register-file read-after-write hazards.
- Sits between the execute/memory writeback sources and the register file.

Parameters:
NUM_REQ, 4, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register index width (32 registers)

Ports:
clock  in  1  rising-edge clock
ctrl_reset  in  1  reset, synchronous, active-low (asserted when 0)
req_valid  in  NUM_REQ  per-requester write request
req_reg  in  NUM_REQ*ADDR_W  destination index; requester i uses bits [i*ADDR_W +: ADDR_W]
req_data  in  NUM_REQ*DATA_W  write data; requester i uses bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot grant (combinational)
rsv_valid  in  1  issue stage reserves a destination register
rsv_reg  in  ADDR_W  register being reserved
chk_reg_a  in  ADDR_W  source A index to check
chk_reg_b  in  ADDR_W  source B index to check
busy_a  out  1  chk_reg_a has a pending write
busy_b  out  1  chk_reg_b has a pending write
busy_vec  out  32  scoreboard contents
ctrl_writeEnable  out  1  register file write enable (registered)
ctrl_writeReg  out  ADDR_W  register file write index (registered)
data_writeReg  out  DATA_W  register file write data (registered)

Behaviour:
- Reset (ctrl_reset==0 at a rising edge):
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - busy_vec=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has top priority first.
  - req_ready is forced to all-zeros combinationally while ctrl_reset==0.
- Arbitration (combinational):
  - Search order is last+1, last+2, …, last (mod NUM_REQ).
  - The first requester with req_valid=1 gets req_ready=1; all others get 0.
  - No valid requests gives req_ready=0.
  - A requester may hold req_valid and must keep req_reg/req_data stable until ready; the arbiter never drops a pending request.
- Transfer: occurs at the edge where req_valid[i] & req_ready[i]. On that edge:
  - last<=i.
  - ctrl_writeReg<=req_reg[i], data_writeReg<=req_data[i].
  - ctrl_writeEnable<=1 if req_reg[i]!=0, else 0. A write to $r0 is consumed but suppressed.
- Latency: accepted at edge N, so ctrl_writeEnable is high throughout cycle N+1 and the register file writes at edge N+1. Throughput is one write per cycle.
- Idle cycle (no transfer): ctrl_writeEnable<=0. ctrl_writeReg and data_writeReg hold their values.
- Scoreboard updates per edge, applied in this order:
  1. Clear busy[ctrl_writeReg] if ctrl_writeEnable==1. This is the same edge the register file commits.
  2. Set busy[rsv_reg] if rsv_valid==1 and rsv_reg!=0.
  - Reserve and clear of the same register on the same edge leaves busy=1 (the new producer wins).
  - busy[0] is hardwired 0.
  - Reserving an already-busy register leaves it 1 (no counting).
- busy_a=busy_vec[chk_reg_a] and busy_b=busy_vec[chk_reg_b], combinational from the registered vector. No bypass: a register whose write commits at edge N reads busy=1 until edge N.
- Reset mid-operation: any accepted-but-uncommitted write is discarded (ctrl_writeEnable=0 after the reset edge) and all reservations are lost.

Test Plan:
1. Reset (ctrl_reset=0 for 2 cycles, all req_valid=1) -> req_ready=0000, ctrl_writeEnable=0, busy_vec=0. After release, the first grant goes to req 0.
2. All 4 requesters valid continuously with regs 1,2,3,4 -> grants 0,1,2,3,0 on consecutive cycles. ctrl_writeReg sequence is 1,2,3,4,1, each one cycle after its grant, with ctrl_writeEnable high every cycle.
3. Req 2 alone writes reg 0 with data 0xDEADBEEF -> req_ready[2]=1 and ctrl_writeReg=0 next cycle with ctrl_writeEnable=0. Reserving reg 0 leaves busy_vec=0.
4. Reserve reg 7 at edge N, then req 1 writes reg 7 = 0x00000055 accepted at edge N+3 -> busy_a (chk_reg_a=7) is 1 from N through N+4, and 0 after edge N+4 when ctrl_writeEnable is high.
5. Same-edge reserve of reg 9 while the committing write targets reg 9 -> busy_vec[9] remains 1 after the edge.
6. Transfer accepted at edge N, ctrl_reset=0 at edge N+1 -> ctrl_writeEnable=0 after N+1, busy_vec=0, and the pointer restarts so req 0 has priority.
